// File: rtl/reg_scoreboard_pkg.sv
// rtl/reg_scoreboard_pkg.sv - shared sizes, RV32I opcode constants and source-use decode
package reg_scoreboard_pkg;

  localparam int NREGS_DEF = 32;
  localparam int AW_DEF    = 5;
  localparam int CNTW_DEF  = 2;

  // RV32I major opcodes (instruction bits [6:0]) shared across the core
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_I_OP   = 7'b0010011;
  localparam logic [6:0] OPC_R_OP   = 7'b0110011;

  // rs1 is read by register/immediate ALU ops, memory ops, branches and jalr
  function automatic logic uses_rs1(input logic [6:0] op);
    case (op)
      OPC_R_OP, OPC_I_OP, OPC_LOAD, OPC_STORE, OPC_BRANCH, OPC_JALR: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // rs2 is read only by register ALU ops, stores and branches
  function automatic logic uses_rs2(input logic [6:0] op);
    case (op)
      OPC_R_OP, OPC_STORE, OPC_BRANCH: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Unrecognised opcodes are treated as harmless: no sources, no write
  function automatic logic known_op(input logic [6:0] op);
    case (op)
      OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH,
      OPC_LOAD, OPC_STORE, OPC_I_OP, OPC_R_OP: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/reg_scoreboard_sb_counter.sv
// rtl/reg_scoreboard_sb_counter.sv - per-register pending-write up/down counter
module sb_counter
  import reg_scoreboard_pkg::*;
#(
  parameter int CNTW = CNTW_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  input  logic dec,
  output logic zero,
  output logic full
);

  logic [CNTW-1:0] r_cnt;

  assign zero = (r_cnt == '0);
  assign full = &r_cnt;

  // Simultaneous inc and dec cancel; guards keep the count from wrapping
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      r_cnt <= '0;
    end else if (inc && !dec && !full) begin
      r_cnt <= r_cnt + 1'b1;
    end else if (dec && !inc && !zero) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

endmodule

// File: rtl/reg_scoreboard.sv
// rtl/reg_scoreboard.sv - issue-side RAW/overflow scoreboard for the RV32I pipeline
module reg_scoreboard
  import reg_scoreboard_pkg::*;
#(
  parameter int NREGS = NREGS_DEF,
  parameter int AW    = AW_DEF,
  parameter int CNTW  = CNTW_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             issue_valid,
  input  logic [31:0]      issue_inst,
  input  logic             issue_rwrite,
  output logic             issue_fire,
  output logic             stall,
  input  logic             wb_valid,
  input  logic [AW-1:0]    wb_rd,
  input  logic             flush,
  output logic [NREGS-1:0] busy,
  output logic             sb_err
);

  logic [6:0]       w_opcode;
  logic [AW-1:0]    w_rs1;
  logic [AW-1:0]    w_rs2;
  logic [AW-1:0]    w_rd;
  logic             w_rwrite;
  logic             w_rs1_haz;
  logic             w_rs2_haz;
  logic             w_rd_full;
  logic             w_issue_wr;
  logic             w_wb_act;
  logic             w_wb_err;
  logic [NREGS-1:0] w_zero;
  logic [NREGS-1:0] w_full;
  logic             w_unused;
  logic             r_err;

  assign w_opcode = issue_inst[6:0];
  assign w_rs1    = issue_inst[15 +: AW];
  assign w_rs2    = issue_inst[20 +: AW];
  assign w_rd     = issue_inst[7 +: AW];
  assign w_unused = ^{issue_inst[31:25], issue_inst[14:12]};

  // x0 is hardwired: never busy, never full
  assign w_zero[0] = 1'b1;
  assign w_full[0] = 1'b0;

  assign w_rwrite  = issue_rwrite && known_op(w_opcode);
  assign w_rs1_haz = uses_rs1(w_opcode) && (w_rs1 != '0) && !w_zero[w_rs1];
  assign w_rs2_haz = uses_rs2(w_opcode) && (w_rs2 != '0) && !w_zero[w_rs2];
  assign w_rd_full = w_rwrite && (w_rd != '0) && w_full[w_rd];

  // Hazards look only at registered counts, so a same-cycle writeback never unblocks
  assign stall      = rst ? 1'b1 : (flush ? 1'b0 : (issue_valid && (w_rs1_haz || w_rs2_haz || w_rd_full)));
  assign issue_fire = issue_valid && !rst && !flush && !stall;

  assign w_issue_wr = issue_fire && w_rwrite && (w_rd != '0);
  assign w_wb_act   = wb_valid && !rst && !flush && (wb_rd != '0);
  assign w_wb_err   = w_wb_act && w_zero[wb_rd];

  genvar gi;
  generate
    for (gi = 1; gi < NREGS; gi++) begin : g_cnt
      logic w_inc;
      logic w_dec;
      assign w_inc = w_issue_wr && (w_rd == AW'(gi));
      assign w_dec = w_wb_act && (wb_rd == AW'(gi)) && !w_zero[gi];
      sb_counter #(.CNTW(CNTW)) u_cnt (
        .clk  (clk),
        .rst  (rst),
        .clr  (flush),
        .inc  (w_inc),
        .dec  (w_dec),
        .zero (w_zero[gi]),
        .full (w_full[gi])
      );
    end
  endgenerate

  assign busy   = ~w_zero;
  assign sb_err = r_err;

  // Sticky underflow flag: only reset clears it, flush leaves it alone
  always_ff @(posedge clk) begin
    if (rst) begin
      r_err <= 1'b0;
    end else if (w_wb_err) begin
      r_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_reg_scoreboard.sv
// tb/tb_reg_scoreboard.sv - scoreboard bench with a counting reference model
module tb_reg_scoreboard;
  import reg_scoreboard_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        issue_valid = 1'b0;
  logic [31:0] issue_inst = '0;
  logic        issue_rwrite = 1'b0;
  logic        issue_fire;
  logic        stall;
  logic        wb_valid = 1'b0;
  logic [4:0]  wb_rd = '0;
  logic        flush = 1'b0;
  logic [31:0] busy;
  logic        sb_err;

  reg_scoreboard dut (
    .clk          (clk),
    .rst          (rst),
    .issue_valid  (issue_valid),
    .issue_inst   (issue_inst),
    .issue_rwrite (issue_rwrite),
    .issue_fire   (issue_fire),
    .stall        (stall),
    .wb_valid     (wb_valid),
    .wb_rd        (wb_rd),
    .flush        (flush),
    .busy         (busy),
    .sb_err       (sb_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        stall;
    logic        fire;
    logic [31:0] busy;
    logic        err;
  } exp_t;

  exp_t q[$];
  int   cnt[32];
  bit   m_err;
  int   n_checks = 0;
  int   n_err = 0;
  localparam int MAXCNT = (1 << CNTW_DEF) - 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mk(input logic [6:0] op, input int rd, input int rs1, input int rs2);
    logic [4:0] a, b, c;
    a = 5'(rd); b = 5'(rs1); c = 5'(rs2);
    return {7'd0, c, b, 3'd0, a, op};
  endfunction

  // Drive one cycle at the falling edge, predict outputs, then advance the model
  task automatic cycle(input logic v, input logic [31:0] inst, input logic rw,
                       input logic wv, input logic [4:0] wr, input logic fl, input logic rs);
    exp_t e;
    logic [6:0] op;
    int r1, r2, rd;
    bit writes, h1, h2, full;
    @(negedge clk);
    issue_valid = v; issue_inst = inst; issue_rwrite = rw;
    wb_valid = wv; wb_rd = wr; flush = fl; rst = rs;
    op = inst[6:0];
    r1 = int'(inst[19:15]); r2 = int'(inst[24:20]); rd = int'(inst[11:7]);
    e.busy = '0;
    for (int i = 1; i < 32; i++) e.busy[i] = (cnt[i] != 0);
    e.err = m_err;
    if (rs) begin
      e.stall = 1'b1; e.fire = 1'b0;
      for (int i = 0; i < 32; i++) cnt[i] = 0;
      m_err = 1'b0;
    end else if (fl) begin
      e.stall = 1'b0; e.fire = 1'b0;
      for (int i = 0; i < 32; i++) cnt[i] = 0;
    end else begin
      writes = rw && (op inside {OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH,
                                  OPC_LOAD, OPC_STORE, OPC_I_OP, OPC_R_OP});
      h1 = (op inside {OPC_R_OP, OPC_I_OP, OPC_LOAD, OPC_STORE, OPC_BRANCH, OPC_JALR})
           && r1 != 0 && cnt[r1] > 0;
      h2 = (op inside {OPC_R_OP, OPC_STORE, OPC_BRANCH}) && r2 != 0 && cnt[r2] > 0;
      full = writes && rd != 0 && cnt[rd] == MAXCNT;
      e.stall = v && (h1 || h2 || full);
      e.fire = v && !e.stall;
      if (wv && wr != 0) begin
        if (cnt[wr] == 0) m_err = 1'b1;
        else cnt[wr]--;
      end
      if (e.fire && writes && rd != 0) cnt[rd]++;
    end
    q.push_back(e);
  endtask

  task automatic idle();
    cycle(1'b0, 32'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
  endtask

  function automatic logic [6:0] pick_op(input int k);
    case (k)
      0: return OPC_LUI;
      1: return OPC_AUIPC;
      2: return OPC_JAL;
      3: return OPC_JALR;
      4: return OPC_BRANCH;
      5: return OPC_LOAD;
      6: return OPC_STORE;
      7: return OPC_I_OP;
      8: return OPC_R_OP;
      default: return 7'b1111111;
    endcase
  endfunction

  // Monitor: compares every presented cycle against the queued prediction
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (q.size() > 0) begin
        e = q.pop_front();
        check("stall", {31'd0, stall}, {31'd0, e.stall});
        check("issue_fire", {31'd0, issue_fire}, {31'd0, e.fire});
        check("busy", busy, e.busy);
        check("sb_err", {31'd0, sb_err}, {31'd0, e.err});
      end
    end
  end

  initial begin
    logic [31:0] sub6, lui7, addi8, inst;
    logic [6:0] op;
    logic rw, wv, fl, rs;
    logic [4:0] wr;
    int r;
    for (int i = 0; i < 32; i++) cnt[i] = 0;
    m_err = 1'b0;

    // reset held for two cycles
    cycle(1'b0, 32'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1); #3;
    check("rst_stall", {31'd0, stall}, 32'd1);
    cycle(1'b1, mk(OPC_LUI, 3, 0, 0), 1'b1, 1'b0, 5'd0, 1'b0, 1'b1); #3;
    check("rst_fire", {31'd0, issue_fire}, 32'd0);
    idle(); #3;
    check("post_rst_stall", {31'd0, stall}, 32'd0);
    check("post_rst_busy", busy, 32'd0);

    // RAW hazard on x5, no bypass from same-cycle writeback
    cycle(1'b1, mk(OPC_R_OP, 5, 1, 2), 1'b1, 1'b0, 5'd0, 1'b0, 1'b0); #3;
    check("add_fire", {31'd0, issue_fire}, 32'd1);
    sub6 = mk(OPC_R_OP, 6, 5, 3);
    cycle(1'b1, sub6, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0); #3;
    check("raw_stall", {31'd0, stall}, 32'd1);
    check("busy5", {31'd0, busy[5]}, 32'd1);
    cycle(1'b1, sub6, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0); #3;
    check("raw_wb_same_cycle", {31'd0, stall}, 32'd1);
    cycle(1'b1, sub6, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0); #3;
    check("raw_cleared", {31'd0, stall}, 32'd0);

    // counter saturation on x7
    lui7 = mk(OPC_LUI, 7, 0, 0);
    for (int k = 0; k < 3; k++) cycle(1'b1, lui7, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0);
    cycle(1'b1, lui7, 1'b1, 1'b1, 5'd7, 1'b0, 1'b0); #3;
    check("rd_full_stall", {31'd0, stall}, 32'd1);
    cycle(1'b1, lui7, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0); #3;
    check("rd_full_issue", {31'd0, issue_fire}, 32'd1);

    // issue and retire same rd cancel
    addi8 = mk(OPC_I_OP, 8, 0, 0);
    cycle(1'b1, addi8, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0);
    cycle(1'b1, addi8, 1'b1, 1'b1, 5'd8, 1'b0, 1'b0);
    idle(); #3;
    check("busy8_held", {31'd0, busy[8]}, 32'd1);
    cycle(1'b0, 32'd0, 1'b0, 1'b1, 5'd8, 1'b0, 1'b0);
    idle(); #3;
    check("busy8_drained", {31'd0, busy[8]}, 32'd0);

    // x0 is never tracked; underflow sets sticky error
    cycle(1'b1, mk(OPC_I_OP, 0, 0, 0), 1'b1, 1'b1, 5'd0, 1'b0, 1'b0); #3;
    check("x0_stall", {31'd0, stall}, 32'd0);
    idle(); #3;
    check("x0_err", {31'd0, sb_err}, 32'd0);
    check("x0_busy0", {31'd0, busy[0]}, 32'd0);
    cycle(1'b0, 32'd0, 1'b0, 1'b1, 5'd9, 1'b0, 1'b0);
    idle(); #3;
    check("underflow_err", {31'd0, sb_err}, 32'd1);
    idle(); #3;
    check("underflow_sticky", {31'd0, sb_err}, 32'd1);

    // flush discards pending writes but keeps sb_err
    cycle(1'b1, mk(OPC_LUI, 3, 0, 0), 1'b1, 1'b0, 5'd0, 1'b0, 1'b0);
    cycle(1'b1, mk(OPC_LUI, 4, 0, 0), 1'b1, 1'b0, 5'd0, 1'b0, 1'b0);
    cycle(1'b1, mk(OPC_LUI, 10, 0, 0), 1'b1, 1'b0, 5'd0, 1'b0, 1'b0);
    cycle(1'b1, mk(OPC_LUI, 11, 0, 0), 1'b1, 1'b1, 5'd3, 1'b1, 1'b0); #3;
    check("flush_fire", {31'd0, issue_fire}, 32'd0);
    idle(); #3;
    check("flush_busy", busy, 32'd0);
    check("flush_keeps_err", {31'd0, sb_err}, 32'd1);

    cycle(1'b0, 32'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1);
    cycle(1'b0, 32'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1);

    // randomized traffic over a small register window to provoke hazards
    for (int n = 0; n < 3000; n++) begin
      op = pick_op(int'($urandom_range(0, 9)));
      inst = {$urandom} & 32'hFE0F_F07F;
      inst[6:0] = op;
      inst[11:7] = 5'($urandom_range(0, 7));
      inst[19:15] = 5'($urandom_range(0, 7));
      inst[24:20] = 5'($urandom_range(0, 7));
      inst[31:25] = 7'($urandom);
      inst[14:12] = 3'($urandom);
      rw = (op == OPC_STORE || op == OPC_BRANCH) ? 1'b0 :
           (op == 7'b1111111) ? 1'($urandom) : 1'b1;
      r = int'($urandom_range(0, 7));
      wr = 5'(r);
      wv = 1'($urandom) && (cnt[r] > 0 || $urandom_range(0, 60) == 0);
      fl = ($urandom_range(0, 24) == 0);
      rs = ($urandom_range(0, 399) == 0);
      cycle(1'($urandom_range(0, 3) != 0), inst, rw, wv, wr, fl, rs);
    end

    idle();
    @(negedge clk);
    #4;
    if (q.size() != 0) begin
      n_checks++;
      n_err++;
      $display("FAIL drain: %0d predictions left, expected 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
